// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
//   uart_state_e : frame state encoding (IDLE, START, DATA, PARITY, STOP)
//   DATA_W       : data bits per frame
//   FRAME_BITS   : start + data + parity + stop
//   IDLE_LEVEL   : line level between frames
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int   DATA_W     = 32;
    localparam int   FRAME_BITS = 35;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..TICK-1 while enabled and flags the last
// clock of each bit period.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   enable    : advance the counter this clock
//   clear     : restart the bit period (wins over enable)
//   tick_last : counter is at TICK-1 (current clock ends the bit)
module uart_baud_tick #(
    parameter int TICK = 10416
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick_last
);

    localparam int            CW   = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_last = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx32.sv
// 32-bit UART transmitter: start(0), 32 data bits LSB first, parity, stop(1),
// every bit held for TICK clocks.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   enable     : freezes all state and the line when low
//   tx_data    : word to send, sampled on accept
//   tx_valid   : upstream word available
//   tx_ready   : idle and enabled; accept = tx_valid && tx_ready
//   serial_out : registered UART line, idles high
//   busy       : frame in progress (cycle after accept .. end of stop bit)
//   done       : one-clock pulse in the last cycle of the stop bit
module uart_tx32
    import uart_pkg::*;
#(
    parameter int TICK       = 10416,
    parameter int DATA_W     = 32,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              done
);

    localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);

    uart_state_e       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [4:0]        bit_q, bit_d;
    logic              par_q, par_d;
    logic              serial_q, serial_d;
    logic              busy_q, busy_d;
    logic              accept, run, tick_last;

    assign tx_ready = enable && (state_q == IDLE);
    assign accept   = tx_valid && tx_ready;
    // Bit timer only runs while a frame is in flight and the block is enabled.
    assign run      = enable && (state_q != IDLE);

    uart_baud_tick #(.TICK(TICK)) u_baud (
        .clk       (clk),
        .rst       (rst),
        .enable    (run),
        .clear     (accept),
        .tick_last (tick_last)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        busy_d  = busy_q;
        done    = 1'b0;
        if (accept) begin
            state_d = START;
            shift_d = tx_data;
            par_d   = (^tx_data) ^ PARITY_ODD;
            busy_d  = 1'b1;
        end else if (run && tick_last) begin
            case (state_q)
                START: begin
                    state_d = DATA;
                    bit_d   = '0;
                end
                DATA: begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        state_d = PARITY;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
                PARITY: state_d = STOP;
                STOP: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done    = 1'b1;
                end
                default: ;
            endcase
        end

        // Line level is registered from the next state so it lines up with
        // the state/tick counter; a frozen frame recomputes the same level.
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = par_d;
            default: serial_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            par_q    <= 1'b0;
            serial_q <= IDLE_LEVEL;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            par_q    <= par_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
        end
    end

    assign serial_out = serial_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx32.sv
// Directed bench for uart_tx32: an even-parity and an odd-parity instance
// share all inputs; each frame is decoded from the line and checked bit by
// bit against a frame built from the word.
module tb_uart_tx32;

    localparam int TICK = 4;
    localparam int FCYC = 35 * TICK;

    logic        clk = 1'b0;
    logic        rst, enable, tx_valid;
    logic [31:0] tx_data;
    logic [1:0]  rdy, ser, bsy, dn;

    int total = 0;
    int bad   = 0;

    uart_tx32 #(.TICK(TICK), .DATA_W(32), .PARITY_ODD(1'b0)) u_even (
        .clk(clk), .rst(rst), .enable(enable), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy[0]), .serial_out(ser[0]), .busy(bsy[0]), .done(dn[0])
    );

    uart_tx32 #(.TICK(TICK), .DATA_W(32), .PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .rst(rst), .enable(enable), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy[1]), .serial_out(ser[1]), .busy(bsy[1]), .done(dn[1])
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Send one word and check the whole frame on both instances. Called at a
    // negedge; returns at the negedge of the cycle after done.
    task automatic frame(input logic [31:0] w, input logic par, input bit keep,
                         input int stall_at, input int stall_n, input string nm,
                         output int waited);
        logic [34:0] exp_f;
        logic [31:0] got [2];
        int          lerr [2];
        int          derr, herr;
        logic        held [2];
        exp_f    = {1'b1, par, w, 1'b0};
        tx_data  = w;
        tx_valid = 1'b1;
        waited   = 0;
        while (!(rdy[0] && rdy[1]) && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        if (!keep) tx_valid = 1'b0;
        lerr = '{0, 0};
        got  = '{32'h0, 32'h0};
        derr = 0;
        herr = 0;
        for (int n = 1; n <= FCYC; n++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                int   b;
                logic e;
                b = (n - 1) / TICK;
                e = (b == 33) ? (par ^ d[0]) : exp_f[b];
                if (ser[d] !== e) lerr[d]++;
                if (b >= 1 && b <= 32 && ((n - 1) % TICK) == 1) got[d][b-1] = ser[d];
                if (dn[d] !== (n == FCYC)) derr++;
                if (bsy[d] !== 1'b1 || rdy[d] !== 1'b0) derr++;
            end
            if (n == stall_at && stall_n > 0) begin
                held[0] = ser[0];
                held[1] = ser[1];
                enable  = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    for (int d = 0; d < 2; d++)
                        if (ser[d] !== held[d] || dn[d] !== 1'b0 || rdy[d] !== 1'b0) herr++;
                end
                enable = 1'b1;
            end
        end
        chk({nm, " line even"}, lerr[0], 0);
        chk({nm, " line odd"}, lerr[1], 0);
        chk({nm, " word even"}, got[0], w);
        chk({nm, " word odd"}, got[1], w);
        chk({nm, " done/busy timing"}, derr, 0);
        if (stall_n > 0) chk({nm, " stall hold"}, herr, 0);
        @(negedge clk);
        chk({nm, " after stop {busy,ready,line,done}"}, {bsy, rdy, ser, dn}, 8'b00_11_11_00);
    endtask

    typedef struct {
        logic [31:0] w;
        logic        par;
        bit          keep;
        bit          stall;
    } vec_t;

    initial begin
        vec_t tv [7];
        int   waited, ierr, derr;

        // even-parity bit expected on the line; odd instance sees its inverse
        tv[0] = '{32'hA5A5_0F01, 1'b1, 1'b0, 1'b0};
        tv[1] = '{32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0};
        tv[2] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0};
        tv[3] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        tv[4] = '{32'h0000_0003, 1'b0, 1'b0, 1'b0};
        tv[5] = '{32'h0000_0007, 1'b1, 1'b0, 1'b0};
        tv[6] = '{32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; enable = 1'b1; tx_valid = 1'b0; tx_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset {busy,ready,line,done}", {bsy, rdy, ser, dn}, 8'b00_11_11_00);
        ierr = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if ({bsy, rdy, ser, dn} !== 8'b00_11_11_00) ierr++;
        end
        chk("idle 50 cycles", ierr, 0);

        for (int i = 0; i < 7; i++) begin
            frame(tv[i].w, tv[i].par, tv[i].keep, tv[i].stall ? 26 : 0, 10,
                  $sformatf("v%0d", i), waited);
            // ready is back in the cycle after done, so the next word goes at once
            chk($sformatf("v%0d accept wait", i), waited, 0);
        end

        // Reset in the middle of the parity bit of 0xCAFEF00D (even parity 0).
        tx_data  = 32'hCAFE_F00D;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        derr = 0;
        for (int c = 1; c <= 33 * TICK + 1; c++) begin
            @(negedge clk);
            if (dn !== 2'b00) derr++;
        end
        chk("mid-frame parity bit", ser, 2'b10);
        rst = 1'b1; tx_valid = 1'b1; tx_data = 32'h5555_5555;
        @(negedge clk);
        chk("mid-frame reset {busy,ready,line,done}", {bsy, rdy, ser, dn}, 8'b00_11_11_00);
        @(negedge clk);
        chk("reset beats valid busy", bsy, 2'b00);
        chk("no done before reset", derr, 0);
        rst = 1'b0; tx_valid = 1'b0;
        frame(32'h1234_5678, 1'b1, 1'b0, 0, 0, "after reset", waited);
        chk("after reset accept wait", waited, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
